stage_phase_accumulator: RTL and testbench
==========================================

// Module: stage_phase_accumulator
// PURPOSE
//  First synth pipeline stage; directly feeds stage_modulator.
//  Round-robins over all voice-operator slots, one slot per clock, and keeps a per-slot phase accumulator.
//  Each visit adds the slot's frequency step to its accumulator and emits the raw unsigned 16-bit phase.
//  Also emits the slot's ID and note-on flag.
// PARAMETERS
//  NUM_SLOTS  256  voice-operator slots (= `NUM_VOICE_OPERATORS); power of two
//  ACC_BITS   24   accumulator width; o_Phase = acc[ACC_BITS-1 -: 16]; >= 16
// PORTS
//  i_Clock                 in   1    system clock, all state on rising edge
//  i_Reset_n               in   1    asynchronous, active-low reset
//  o_Phase                 out  16   unsigned phase of o_VoiceOperator's slot
//  o_NoteOn                out  1    stored note-on flag of that slot
//  o_VoiceOperator         out  `VOICE_OPERATOR_ID  slot ID of this output beat
//  o_Valid                 out  1    1 = outputs carry a real slot (RUN state, pipe full)
//  i_FrequencyWriteEnable  in   1    write i_ConfigWriteData to slot's frequency step
//  i_NoteOnWriteEnable     in   1    write i_ConfigWriteData[0] to slot's note-on flag
//  i_ConfigWriteAddr       in   `VOICE_OPERATOR_ID  target slot of config write
//  i_ConfigWriteData       in   16   config data; step is zero-extended to ACC_BITS
// BEHAVIOUR
//  Reset, async on i_Reset_n=0:
//   - o_Phase=0, o_NoteOn=0, o_VoiceOperator=0, o_Valid=0; all pipe registers 0
//   - FSM enters CLEAR; sweep counter = 0
//  FSM, two states:
//   - CLEAR: one slot per clock. Write phase=0, step=0, note-on=0, prev-note-on=0 at the sweep counter.
//     After slot NUM_SLOTS-1, go to RUN and reset the issue counter to 0.
//     Config writes during CLEAR are dropped.
//   - RUN: issue counter increments every clock and wraps NUM_SLOTS-1 -> 0. No stall input exists.
//  Pipeline, 2 cycles, issue -> output:
//   - C1: read step, acc, note-on and prev-note-on for the issued ID.
//   - C2: compute new acc. Write back acc and prev-note-on. Register outputs.
//   - o_VoiceOperator lags the issue counter by 2. o_Valid rises 2 clocks after entering RUN and then stays 1.
//  Arithmetic:
//   - acc_next = acc + zext(step), modulo 2^ACC_BITS; wraps silently.
//   - Note-on rising edge (note-on=1, prev=0): acc_next = 0 and o_Phase = 0 on this visit (phase restart).
//   - Note-on falling edge or steady state: normal accumulation. Phase keeps running in release.
//   - prev-note-on <= note-on on every visit.
//  Config writes (RUN only):
//   - Take effect at the next clock edge.
//   - A read of the same slot in the same cycle returns the old value (read-before-write).
//   - The new value applies from the slot's next visit.
//   - Both enables high in the same cycle: both writes happen. Same 16-bit data; note-on uses bit 0.
//  Hazards:
//   - A slot is revisited every NUM_SLOTS clocks, and NUM_SLOTS > pipe depth.
//   - So accumulator write-back never conflicts with a read of the same slot; no forwarding needed.
//  Reset mid-operation:
//   - Outputs drop to 0 immediately.
//   - After release, a full CLEAR sweep (NUM_SLOTS clocks) runs before any valid beat.
//   - All prior config is lost.
// TESTING
//  1. Release reset: o_Valid=0 for NUM_SLOTS+2 clocks, then 1. First valid o_VoiceOperator=0, then 1,2,...; wraps 255->0.
//  2. Step[5]=0x0100, note-on[5]=1. First visit of slot 5: o_Phase=0, o_NoteOn=1.
//     Nth later visit: o_Phase=(N*0x0100)>>8 (ACC_BITS=24). Other slots stay 0.
//  3. Step[9]=0xFFFF, note-on held: accumulator wraps past 2^24; o_Phase equals (sum mod 2^24)>>8 with no error flag.
//  4. Slot 3 accumulating; write note-on[3]=0, then =1. The visit after the 0->1 write shows o_Phase=0, then accumulation restarts.
//  5. Frequency write to slot 7 in the same cycle slot 7 is issued: this visit uses the old step, the next visit the new step.
//  6. Assert i_Reset_n=0 mid-RUN: outputs 0 asynchronously. Config writes during the next CLEAR are ignored. All slots read phase 0 afterward.

Source files
------------

// File: rtl/stage_phase_accumulator.sv
// stage_phase_accumulator
//   First synth pipeline stage. Visits one voice-operator slot per clock in
//   round-robin order, advances that slot's phase accumulator by its frequency
//   step and emits the top 16 bits of the accumulator as the raw phase.
//
//   Ports
//     i_Clock, i_Reset_n      clock (rising edge), async active-low reset
//     o_Phase                 unsigned 16-bit phase of the output slot
//     o_NoteOn                stored note-on flag of the output slot
//     o_VoiceOperator         slot ID of this output beat
//     o_Valid                 outputs carry a real slot
//     i_FrequencyWriteEnable  write i_ConfigWriteData to the slot's step
//     i_NoteOnWriteEnable     write i_ConfigWriteData[0] to the slot's note-on
//     i_ConfigWriteAddr       target slot of a config write
//     i_ConfigWriteData       config data
module stage_phase_accumulator #(
  parameter  int unsigned NUM_SLOTS = 256,
  parameter  int unsigned ACC_BITS  = 24,
  localparam int unsigned ID_BITS   = $clog2(NUM_SLOTS)
) (
  input  logic               i_Clock,
  input  logic               i_Reset_n,
  output logic [15:0]        o_Phase,
  output logic               o_NoteOn,
  output logic [ID_BITS-1:0] o_VoiceOperator,
  output logic               o_Valid,
  input  logic               i_FrequencyWriteEnable,
  input  logic               i_NoteOnWriteEnable,
  input  logic [ID_BITS-1:0] i_ConfigWriteAddr,
  input  logic [15:0]        i_ConfigWriteData
);

  localparam int unsigned PHASE_BITS = 16;
  localparam int unsigned STEP_BITS  = 16;

  typedef enum logic {CLEAR, RUN} stateType;

  stateType           state;
  stateType           nextState;
  logic [ID_BITS-1:0] sweepCount;
  logic [ID_BITS-1:0] issueCount;

  // Per-slot storage; cleared by the CLEAR sweep rather than by reset.
  logic [STEP_BITS-1:0] stepMem       [NUM_SLOTS];
  logic [ACC_BITS-1:0]  accMem        [NUM_SLOTS];
  logic                 noteOnMem     [NUM_SLOTS];
  logic                 prevNoteOnMem [NUM_SLOTS];

  // Stage-1 (read) registers
  logic                 s1Valid;
  logic [ID_BITS-1:0]   s1Id;
  logic [STEP_BITS-1:0] s1Step;
  logic [ACC_BITS-1:0]  s1Acc;
  logic                 s1NoteOn;
  logic                 s1PrevNoteOn;

  logic [ACC_BITS-1:0]  accNext;

  // State register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= CLEAR;
    end else begin
      state <= nextState;
    end
  end

  // Next-state: leave CLEAR once the last slot has been wiped
  always_comb begin
    nextState = state;
    case (state)
      CLEAR:   if (sweepCount == ID_BITS'(NUM_SLOTS - 1)) nextState = RUN;
      RUN:     nextState = RUN;
      default: nextState = CLEAR;
    endcase
  end

  // Sweep and issue counters; issue restarts at 0 on every CLEAR->RUN entry
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sweepCount <= '0;
      issueCount <= '0;
    end else if (state == CLEAR) begin
      sweepCount <= sweepCount + ID_BITS'(1);
      issueCount <= '0;
    end else begin
      issueCount <= issueCount + ID_BITS'(1);
    end
  end

  // Slot storage writes: sweep clear, config writes, stage-2 write-back
  always_ff @(posedge i_Clock) begin
    if (state == CLEAR) begin
      stepMem[sweepCount]       <= '0;
      accMem[sweepCount]        <= '0;
      noteOnMem[sweepCount]     <= 1'b0;
      prevNoteOnMem[sweepCount] <= 1'b0;
    end else begin
      if (i_FrequencyWriteEnable) stepMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
      if (i_NoteOnWriteEnable) noteOnMem[i_ConfigWriteAddr] <= i_ConfigWriteData[0];
      if (s1Valid) begin
        accMem[s1Id]        <= accNext;
        prevNoteOnMem[s1Id] <= s1NoteOn;
      end
    end
  end

  // Stage 1: read the issued slot; fields held at 0 outside RUN so idle beats are all-zero
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s1Valid      <= 1'b0;
      s1Id         <= '0;
      s1Step       <= '0;
      s1Acc        <= '0;
      s1NoteOn     <= 1'b0;
      s1PrevNoteOn <= 1'b0;
    end else if (state == RUN) begin
      s1Valid      <= 1'b1;
      s1Id         <= issueCount;
      s1Step       <= stepMem[issueCount];
      s1Acc        <= accMem[issueCount];
      s1NoteOn     <= noteOnMem[issueCount];
      s1PrevNoteOn <= prevNoteOnMem[issueCount];
    end else begin
      s1Valid      <= 1'b0;
      s1Id         <= '0;
      s1Step       <= '0;
      s1Acc        <= '0;
      s1NoteOn     <= 1'b0;
      s1PrevNoteOn <= 1'b0;
    end
  end

  // Stage 2 arithmetic: a note-on rising edge restarts the phase at 0
  always_comb begin
    accNext = s1Acc + ACC_BITS'(s1Step);
    if (s1NoteOn && !s1PrevNoteOn) accNext = '0;
  end

  // Stage 2 output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_Phase         <= '0;
      o_NoteOn        <= 1'b0;
      o_VoiceOperator <= '0;
      o_Valid         <= 1'b0;
    end else begin
      o_Phase         <= accNext[ACC_BITS-1 -: PHASE_BITS];
      o_NoteOn        <= s1NoteOn;
      o_VoiceOperator <= s1Id;
      o_Valid         <= s1Valid;
    end
  end

endmodule

// File: tb/tb_stage_phase_accumulator.sv
// Bench for stage_phase_accumulator: directed scenarios mixed with random
// config writes, checked against a per-visit behavioural model of the slots.
module tb_stage_phase_accumulator;

  localparam int S    = 32;
  localparam int ACC  = 24;
  localparam int IDW  = $clog2(S);
  localparam longint MASK = (64'd1 << ACC) - 1;

  logic           i_Clock = 1'b0;
  logic           i_Reset_n;
  logic [15:0]    o_Phase;
  logic           o_NoteOn;
  logic [IDW-1:0] o_VoiceOperator;
  logic           o_Valid;
  logic           i_FrequencyWriteEnable;
  logic           i_NoteOnWriteEnable;
  logic [IDW-1:0] i_ConfigWriteAddr;
  logic [15:0]    i_ConfigWriteData;

  stage_phase_accumulator #(.NUM_SLOTS(S), .ACC_BITS(ACC)) dut (
    .i_Clock                (i_Clock),
    .i_Reset_n              (i_Reset_n),
    .o_Phase                (o_Phase),
    .o_NoteOn               (o_NoteOn),
    .o_VoiceOperator        (o_VoiceOperator),
    .o_Valid                (o_Valid),
    .i_FrequencyWriteEnable (i_FrequencyWriteEnable),
    .i_NoteOnWriteEnable    (i_NoteOnWriteEnable),
    .i_ConfigWriteAddr      (i_ConfigWriteAddr),
    .i_ConfigWriteData      (i_ConfigWriteData)
  );

  always #5 i_Clock = ~i_Clock;

  int total = 0;
  int bad   = 0;

  // Model: slot contents plus the one visit that is in flight
  int     mStep [S];
  bit     mNote [S];
  bit     mPrev [S];
  longint mAcc  [S];
  int     edgeCount;
  bit     pendValid;
  int     pendId;
  int     pendStep;
  bit     pendNote;

  function automatic void modelReset();
    for (int i = 0; i < S; i++) begin
      mStep[i] = 0; mNote[i] = 0; mPrev[i] = 0; mAcc[i] = 0;
    end
    edgeCount = 0;
    pendValid = 0;
    pendId = 0; pendStep = 0; pendNote = 0;
  endfunction

  task automatic checkZero(input string tag);
    total++;
    assert (o_Phase === 16'd0) else begin bad++; $error("FAIL %s phase got=%0h want=0", tag, o_Phase); end
    total++;
    assert (o_NoteOn === 1'b0) else begin bad++; $error("FAIL %s noteon got=%0b want=0", tag, o_NoteOn); end
    total++;
    assert (o_VoiceOperator === '0) else begin bad++; $error("FAIL %s id got=%0d want=0", tag, o_VoiceOperator); end
    total++;
    assert (o_Valid === 1'b0) else begin bad++; $error("FAIL %s valid got=%0b want=0", tag, o_Valid); end
  endtask

  // One clock: drive config, advance model, compare outputs
  task automatic tick(input bit fwe, input bit nwe, input int addr, input int data);
    bit     expValid;
    int     expId;
    int     expPhase;
    bit     expNote;
    longint newAcc;
    int     id;
    i_FrequencyWriteEnable = fwe;
    i_NoteOnWriteEnable    = nwe;
    i_ConfigWriteAddr      = IDW'(addr);
    i_ConfigWriteData      = 16'(data);
    @(posedge i_Clock);
    #1;
    edgeCount++;
    expValid = pendValid;
    expId = 0; expPhase = 0; expNote = 0;
    if (pendValid) begin
      if (pendNote && !mPrev[pendId]) newAcc = 0;
      else newAcc = (mAcc[pendId] + longint'(pendStep)) & MASK;
      mAcc[pendId]  = newAcc;
      mPrev[pendId] = pendNote;
      expId    = pendId;
      expNote  = pendNote;
      expPhase = int'((newAcc >> (ACC - 16)) & 64'hFFFF);
    end
    // First S edges after reset are the clear sweep; issue starts on edge S+1
    if (edgeCount >= S + 1) begin
      id        = (edgeCount - (S + 1)) % S;
      pendValid = 1;
      pendId    = id;
      pendStep  = mStep[id];
      pendNote  = mNote[id];
      if (fwe) mStep[addr] = data & 16'hFFFF;
      if (nwe) mNote[addr] = data[0];
    end else begin
      pendValid = 0;
    end
    i_FrequencyWriteEnable = 1'b0;
    i_NoteOnWriteEnable    = 1'b0;
    total++;
    assert (o_Valid === expValid) else begin bad++; $error("FAIL valid e=%0d got=%0b want=%0b", edgeCount, o_Valid, expValid); end
    total++;
    assert (o_VoiceOperator === IDW'(expId)) else begin bad++; $error("FAIL id e=%0d got=%0d want=%0d", edgeCount, o_VoiceOperator, expId); end
    total++;
    assert (o_Phase === 16'(expPhase)) else begin bad++; $error("FAIL phase e=%0d slot=%0d got=%0h want=%0h", edgeCount, expId, o_Phase, expPhase); end
    total++;
    assert (o_NoteOn === expNote) else begin bad++; $error("FAIL noteon e=%0d slot=%0d got=%0b want=%0b", edgeCount, expId, o_NoteOn, expNote); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask

  // Random config traffic restricted to slots not used by directed scenarios
  task automatic randomTicks(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0)
        tick(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(S - 1, 10)),
             int'($urandom_range(16'hFFFF)));
      else
        tick(0, 0, 0, 0);
    end
  endtask

  initial begin
    i_Reset_n              = 1'b1;
    i_FrequencyWriteEnable = 1'b0;
    i_NoteOnWriteEnable    = 1'b0;
    i_ConfigWriteAddr      = '0;
    i_ConfigWriteData      = '0;
    modelReset();

    // Power-on reset and sweep; valid rises two clocks after RUN entry
    #2 i_Reset_n = 1'b0;
    #2 checkZero("por");
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    idle(3 * S);

    // Slot 5 restart and steady accumulation; slot 9 near-max step, both enables at once
    tick(1, 0, 5, 16'h0100);
    tick(0, 1, 5, 1);
    tick(1, 1, 9, 16'hFFFF);
    tick(1, 1, 3, 16'h1235);
    tick(1, 0, 7, 16'h0010);
    tick(0, 1, 7, 1);
    idle(4 * S);

    // Slot 3 note-off then note-on: phase restarts on the visit after the rising write
    tick(0, 1, 3, 0);
    randomTicks(2 * S);
    tick(0, 1, 3, 1);
    randomTicks(3 * S);

    // Frequency write to slot 7 on the very edge slot 7 is issued
    for (int g = 0; g < 2 * S && (((edgeCount + 1) - (S + 1)) % S) != 7; g++) tick(0, 0, 0, 0);
    tick(1, 0, 7, 16'h0400);
    idle(3 * S);

    // Long run so slot 9's accumulator wraps past 2^24
    randomTicks(260 * S);

    // Mid-run asynchronous reset
    #2 i_Reset_n = 1'b0;
    #1 checkZero("midrst");
    @(posedge i_Clock);
    #1 checkZero("midrst_hold");
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    modelReset();
    // Writes during the sweep must be dropped
    for (int i = 0; i < S; i++) tick(1, 1, int'($urandom_range(S - 1)), 16'hFFFF);
    idle(3 * S);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
